// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, bus mux and ALU.
// The control unit drives every strobe; memory and IO connect through MDR/MAR/InPort/OutPort.
module datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        R0_select,
    input  logic        R1_select,
    input  logic        R2_select,
    input  logic        PC_select,
    input  logic        MDR_select,
    input  logic        InPort_select,
    input  logic        HI_select,
    input  logic        LO_select,
    input  logic        ZHI_select,
    input  logic        ZLO_select,
    input  logic        C_select,
    input  logic        PC_select_write,
    input  logic        MAR_select_write,
    input  logic        OutPort_select_write,
    input  logic        HI_select_write,
    input  logic        LO_select_write,
    input  logic        C_select_write,
    input  logic        RY_select_write,
    input  logic        MDR_select_write,
    input  logic        InPort_select_write,
    input  logic        ZHI_select_write,
    input  logic        ZLO_select_write,
    input  logic        RF_enable,
    input  logic [3:0]  RF_write,
    input  logic        AND_select,
    input  logic        OR_select,
    input  logic        ADD_select,
    input  logic        SUB_select,
    input  logic        MUL_select,
    input  logic        DIV_select,
    input  logic        SHR_select,
    input  logic        SHRA_select,
    input  logic        SHL_select,
    input  logic        ROR_select,
    input  logic        ROL_select,
    input  logic        NEG_select,
    input  logic        NOT_select,
    input  logic [31:0] MDR_data,
    input  logic [31:0] IO_data_in,
    output logic [31:0] IO_data_out,
    output logic [31:0] MAR_data
);

    logic [31:0] rf [16];
    logic [31:0] pc, mdr, mar, inport, outport, hi, lo, y, c, zhi, zlo;
    logic [31:0] bus;
    logic [63:0] res;
    logic [63:0] prod, ror_ext, rol_ext;
    logic [31:0] quo, rem;
    logic [4:0]  sh;

    always_comb begin
        if (R0_select)          bus = rf[0];
        else if (R1_select)     bus = rf[1];
        else if (R2_select)     bus = rf[2];
        else if (PC_select)     bus = pc;
        else if (MDR_select)    bus = mdr;
        else if (InPort_select) bus = inport;
        else if (HI_select)     bus = hi;
        else if (LO_select)     bus = lo;
        else if (ZHI_select)    bus = zhi;
        else if (ZLO_select)    bus = zlo;
        else if (C_select)      bus = c;
        else                    bus = '0;
    end

    assign sh      = bus[4:0];
    // Sign-extending both operands makes the low 64 bits of the product the signed result.
    assign prod    = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};
    assign ror_ext = {y, y} >> sh;
    assign rol_ext = {y, y} << sh;

    always_comb begin
        if (bus == 32'd0) begin
            quo = '1;
            rem = y;
        end else begin
            quo = $signed(y) / $signed(bus);
            rem = $signed(y) % $signed(bus);
        end
    end

    always_comb begin
        res = '0;
        if (AND_select)       res[31:0] = y & bus;
        else if (OR_select)   res[31:0] = y | bus;
        else if (ADD_select)  res[31:0] = y + bus;
        else if (SUB_select)  res[31:0] = y - bus;
        else if (MUL_select)  res       = prod;
        else if (DIV_select)  res       = {rem, quo};
        else if (SHR_select)  res[31:0] = y >> sh;
        else if (SHRA_select) res[31:0] = $signed(y) >>> sh;
        else if (SHL_select)  res[31:0] = y << sh;
        else if (ROR_select)  res[31:0] = ror_ext[31:0];
        else if (ROL_select)  res[31:0] = rol_ext[63:32];
        else if (NEG_select)  res[31:0] = 32'd0 - bus;
        else if (NOT_select)  res[31:0] = ~bus;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            pc      <= '0;
            mdr     <= '0;
            mar     <= '0;
            inport  <= '0;
            outport <= '0;
            hi      <= '0;
            lo      <= '0;
            y       <= '0;
            c       <= '0;
            zhi     <= '0;
            zlo     <= '0;
        end else begin
            if (RF_enable)            rf[RF_write] <= bus;
            if (PC_select_write)      pc      <= bus;
            if (MDR_select_write)     mdr     <= MDR_data;
            if (MAR_select_write)     mar     <= bus;
            if (InPort_select_write)  inport  <= IO_data_in;
            if (OutPort_select_write) outport <= bus;
            if (HI_select_write)      hi      <= bus;
            if (LO_select_write)      lo      <= bus;
            if (RY_select_write)      y       <= bus;
            if (C_select_write)       c       <= bus;
            if (ZHI_select_write)     zhi     <= res[63:32];
            if (ZLO_select_write)     zlo     <= res[31:0];
        end
    end

    assign MAR_data    = mar;
    assign IO_data_out = outport;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath; registers are observed by routing them to MAR.
module tb_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic        R0_select, R1_select, R2_select, PC_select, MDR_select, InPort_select;
    logic        HI_select, LO_select, ZHI_select, ZLO_select, C_select;
    logic        PC_select_write, MAR_select_write, OutPort_select_write, HI_select_write;
    logic        LO_select_write, C_select_write, RY_select_write, MDR_select_write;
    logic        InPort_select_write, ZHI_select_write, ZLO_select_write, RF_enable;
    logic [3:0]  RF_write;
    logic        AND_select, OR_select, ADD_select, SUB_select, MUL_select, DIV_select;
    logic        SHR_select, SHRA_select, SHL_select, ROR_select, ROL_select, NEG_select;
    logic        NOT_select;
    logic [31:0] MDR_data, IO_data_in, IO_data_out, MAR_data;

    int n_checks = 0;
    int n_fail   = 0;

    datapath dut (
        .clk(clk), .clr(clr),
        .R0_select(R0_select), .R1_select(R1_select), .R2_select(R2_select),
        .PC_select(PC_select), .MDR_select(MDR_select), .InPort_select(InPort_select),
        .HI_select(HI_select), .LO_select(LO_select), .ZHI_select(ZHI_select),
        .ZLO_select(ZLO_select), .C_select(C_select),
        .PC_select_write(PC_select_write), .MAR_select_write(MAR_select_write),
        .OutPort_select_write(OutPort_select_write), .HI_select_write(HI_select_write),
        .LO_select_write(LO_select_write), .C_select_write(C_select_write),
        .RY_select_write(RY_select_write), .MDR_select_write(MDR_select_write),
        .InPort_select_write(InPort_select_write), .ZHI_select_write(ZHI_select_write),
        .ZLO_select_write(ZLO_select_write), .RF_enable(RF_enable), .RF_write(RF_write),
        .AND_select(AND_select), .OR_select(OR_select), .ADD_select(ADD_select),
        .SUB_select(SUB_select), .MUL_select(MUL_select), .DIV_select(DIV_select),
        .SHR_select(SHR_select), .SHRA_select(SHRA_select), .SHL_select(SHL_select),
        .ROR_select(ROR_select), .ROL_select(ROL_select), .NEG_select(NEG_select),
        .NOT_select(NOT_select), .MDR_data(MDR_data), .IO_data_in(IO_data_in),
        .IO_data_out(IO_data_out), .MAR_data(MAR_data)
    );

    always #5 clk = ~clk;

    task automatic clear_all();
        clr = 0;
        {R0_select, R1_select, R2_select, PC_select, MDR_select, InPort_select} = '0;
        {HI_select, LO_select, ZHI_select, ZLO_select, C_select} = '0;
        {PC_select_write, MAR_select_write, OutPort_select_write, HI_select_write} = '0;
        {LO_select_write, C_select_write, RY_select_write, MDR_select_write} = '0;
        {InPort_select_write, ZHI_select_write, ZLO_select_write, RF_enable} = '0;
        RF_write = '0;
        {AND_select, OR_select, ADD_select, SUB_select, MUL_select, DIV_select} = '0;
        {SHR_select, SHRA_select, SHL_select, ROR_select, ROL_select, NEG_select} = '0;
        NOT_select = 0;
    endtask

    // Advance one edge, then drop all strobes; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        clear_all();
    endtask

    // 0 R0,1 R1,2 R2,3 PC,4 MDR,5 InPort,6 HI,7 LO,8 ZHI,9 ZLO,10 C
    task automatic set_src(input int s);
        case (s)
            0: R0_select = 1;      1: R1_select = 1;   2: R2_select = 1;
            3: PC_select = 1;      4: MDR_select = 1;  5: InPort_select = 1;
            6: HI_select = 1;      7: LO_select = 1;   8: ZHI_select = 1;
            9: ZLO_select = 1;     10: C_select = 1;
            default: ;
        endcase
    endtask

    // 0 AND,1 OR,2 ADD,3 SUB,4 MUL,5 DIV,6 SHR,7 SHRA,8 SHL,9 ROR,10 ROL,11 NEG,12 NOT
    task automatic set_op(input int o);
        case (o)
            0: AND_select = 1;  1: OR_select = 1;    2: ADD_select = 1;  3: SUB_select = 1;
            4: MUL_select = 1;  5: DIV_select = 1;   6: SHR_select = 1;  7: SHRA_select = 1;
            8: SHL_select = 1;  9: ROR_select = 1;   10: ROL_select = 1; 11: NEG_select = 1;
            12: NOT_select = 1;
            default: ;
        endcase
    endtask

    task automatic read_to_mar(input int s);
        set_src(s);
        MAR_select_write = 1;
        cyc();
    endtask

    task automatic load_inport(input logic [31:0] v);
        IO_data_in = v;
        InPort_select_write = 1;
        cyc();
    endtask

    // Y <= a, then Z <= op(a, b) with b supplied through InPort.
    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input int o);
        load_inport(a);
        InPort_select = 1; RY_select_write = 1;
        cyc();
        load_inport(b);
        InPort_select = 1; set_op(o); ZHI_select_write = 1; ZLO_select_write = 1;
        cyc();
    endtask

    task automatic test_reset();
        clr = 1;
        cyc();
        load_inport(32'h1234);
        InPort_select = 1; MAR_select_write = 1; OutPort_select_write = 1;
        cyc();
        n_checks++;
        if (MAR_data !== 32'h1234) begin
            n_fail++; $display("FAIL pre_reset_mar: got %h want %h", MAR_data, 32'h1234);
        end
        // Reset must win over every strobe active in the same cycle.
        clr = 1; IO_data_in = 32'h5678; InPort_select_write = 1; InPort_select = 1;
        MAR_select_write = 1; OutPort_select_write = 1; RF_enable = 1; RY_select_write = 1;
        cyc();
        n_checks++;
        if (MAR_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_mar: got %h want 0", MAR_data);
        end
        n_checks++;
        if (IO_data_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_outport: got %h want 0", IO_data_out);
        end
        for (int s = 0; s <= 10; s++) begin
            read_to_mar(s);
            n_checks++;
            if (MAR_data !== 32'h0) begin
                n_fail++; $display("FAIL reset_src%0d: got %h want 0", s, MAR_data);
            end
        end
    endtask

    task automatic test_rf_load();
        load_inport(32'd5);
        InPort_select = 1; RF_enable = 1; RF_write = 4'd0;
        cyc();
        load_inport(32'd3);
        InPort_select = 1; RF_enable = 1; RF_write = 4'd1;
        cyc();
        load_inport(32'h99);
        InPort_select = 1; RF_enable = 1; RF_write = 4'd15;
        cyc();
        read_to_mar(0);
        n_checks++;
        if (MAR_data !== 32'd5) begin
            n_fail++; $display("FAIL rf_r0: got %h want 5", MAR_data);
        end
        read_to_mar(1);
        n_checks++;
        if (MAR_data !== 32'd3) begin
            n_fail++; $display("FAIL rf_r1: got %h want 3", MAR_data);
        end
        read_to_mar(2);
        n_checks++;
        if (MAR_data !== 32'd0) begin
            n_fail++; $display("FAIL rf_r2: got %h want 0", MAR_data);
        end
    endtask

    task automatic test_alu_logic();
        logic [31:0] exp_v [4] = '{32'd1, 32'd7, 32'd8, 32'd2};
        R0_select = 1; RY_select_write = 1;
        cyc();
        for (int o = 0; o < 4; o++) begin
            R1_select = 1; set_op(o); ZLO_select_write = 1; ZHI_select_write = 1;
            cyc();
            read_to_mar(9);
            n_checks++;
            if (MAR_data !== exp_v[o]) begin
                n_fail++; $display("FAIL logic_op%0d: got %h want %h", o, MAR_data, exp_v[o]);
            end
        end
        read_to_mar(8);
        n_checks++;
        if (MAR_data !== 32'd0) begin
            n_fail++; $display("FAIL logic_zhi: got %h want 0", MAR_data);
        end
    endtask

    task automatic test_muldiv();
        // {a, b, op, zhi, zlo}
        logic [31:0] v [5][5] = '{
            '{32'hFFFFFFFE, 32'd3,       32'd4, 32'hFFFFFFFF, 32'hFFFFFFFA},
            '{32'h00010000, 32'h00010000, 32'd4, 32'h00000001, 32'h00000000},
            '{32'hFFFFFFF9, 32'd2,       32'd5, 32'hFFFFFFFF, 32'hFFFFFFFD},
            '{32'd7,        32'hFFFFFFFE, 32'd5, 32'h00000001, 32'hFFFFFFFD},
            '{32'h00001234, 32'd0,       32'd5, 32'h00001234, 32'hFFFFFFFF}
        };
        for (int i = 0; i < 5; i++) begin
            alu_op(v[i][0], v[i][1], int'(v[i][2]));
            read_to_mar(8);
            n_checks++;
            if (MAR_data !== v[i][3]) begin
                n_fail++; $display("FAIL muldiv%0d_zhi: got %h want %h", i, MAR_data, v[i][3]);
            end
            read_to_mar(9);
            n_checks++;
            if (MAR_data !== v[i][4]) begin
                n_fail++; $display("FAIL muldiv%0d_zlo: got %h want %h", i, MAR_data, v[i][4]);
            end
        end
    endtask

    task automatic test_shift_unary();
        // {a, b, op, zlo}
        logic [31:0] v [9][4] = '{
            '{32'h80000001, 32'd1,  32'd6,  32'h40000000},
            '{32'h80000001, 32'd1,  32'd7,  32'hC0000000},
            '{32'h80000001, 32'd1,  32'd8,  32'h00000002},
            '{32'h80000001, 32'd1,  32'd9,  32'hC0000000},
            '{32'h80000001, 32'd1,  32'd10, 32'h00000003},
            '{32'h80000001, 32'd33, 32'd8,  32'h00000002},
            '{32'h12345678, 32'd0,  32'd9,  32'h12345678},
            '{32'h0,        32'd1,  32'd11, 32'hFFFFFFFF},
            '{32'h0,        32'd1,  32'd12, 32'hFFFFFFFE}
        };
        for (int i = 0; i < 9; i++) begin
            alu_op(v[i][0], v[i][1], int'(v[i][2]));
            read_to_mar(9);
            n_checks++;
            if (MAR_data !== v[i][3]) begin
                n_fail++; $display("FAIL shift%0d: got %h want %h", i, MAR_data, v[i][3]);
            end
        end
    endtask

    task automatic test_special_regs();
        load_inport(32'hA1); InPort_select = 1; HI_select_write = 1; cyc();
        load_inport(32'hB2); InPort_select = 1; LO_select_write = 1; cyc();
        load_inport(32'hC3); InPort_select = 1; C_select_write = 1; cyc();
        load_inport(32'hD4); InPort_select = 1; PC_select_write = 1; cyc();
        MDR_data = 32'hCAFE; MDR_select_write = 1; cyc();
        read_to_mar(6);
        n_checks++;
        if (MAR_data !== 32'hA1) begin n_fail++; $display("FAIL hi: got %h want a1", MAR_data); end
        read_to_mar(7);
        n_checks++;
        if (MAR_data !== 32'hB2) begin n_fail++; $display("FAIL lo: got %h want b2", MAR_data); end
        read_to_mar(10);
        n_checks++;
        if (MAR_data !== 32'hC3) begin n_fail++; $display("FAIL c: got %h want c3", MAR_data); end
        read_to_mar(3);
        n_checks++;
        if (MAR_data !== 32'hD4) begin n_fail++; $display("FAIL pc: got %h want d4", MAR_data); end
        read_to_mar(4);
        n_checks++;
        if (MAR_data !== 32'hCAFE) begin
            n_fail++; $display("FAIL mdr: got %h want cafe", MAR_data);
        end
    endtask

    task automatic test_priority();
        R1_select = 1; R0_select = 1; HI_select = 1; MAR_select_write = 1;
        cyc();
        n_checks++;
        if (MAR_data !== 32'd5) begin
            n_fail++; $display("FAIL bus_prio: got %h want 5", MAR_data);
        end
        LO_select = 1; HI_select = 1; MAR_select_write = 1;
        cyc();
        n_checks++;
        if (MAR_data !== 32'hA1) begin
            n_fail++; $display("FAIL bus_prio_hilo: got %h want a1", MAR_data);
        end
        MAR_select_write = 1;
        cyc();
        n_checks++;
        if (MAR_data !== 32'd0) begin
            n_fail++; $display("FAIL bus_idle: got %h want 0", MAR_data);
        end
        // AND outranks ADD when both are selected.
        load_inport(32'h0F); InPort_select = 1; RY_select_write = 1; cyc();
        load_inport(32'h3C);
        InPort_select = 1; AND_select = 1; ADD_select = 1; ZLO_select_write = 1;
        cyc();
        read_to_mar(9);
        n_checks++;
        if (MAR_data !== 32'h0C) begin
            n_fail++; $display("FAIL alu_prio: got %h want 0c", MAR_data);
        end
        // No op selected gives zero.
        InPort_select = 1; ZLO_select_write = 1; cyc();
        read_to_mar(9);
        n_checks++;
        if (MAR_data !== 32'h0) begin
            n_fail++; $display("FAIL alu_none: got %h want 0", MAR_data);
        end
    endtask

    task automatic test_outputs();
        R0_select = 1; MAR_select_write = 1; OutPort_select_write = 1;
        cyc();
        n_checks++;
        if (MAR_data !== 32'd5) begin
            n_fail++; $display("FAIL out_mar: got %h want 5", MAR_data);
        end
        n_checks++;
        if (IO_data_out !== 32'd5) begin
            n_fail++; $display("FAIL out_port: got %h want 5", IO_data_out);
        end
        // Outputs are registered: changing the bus without a strobe must not move them.
        R1_select = 1;
        cyc();
        n_checks++;
        if (IO_data_out !== 32'd5 || MAR_data !== 32'd5) begin
            n_fail++;
            $display("FAIL out_hold: got out=%h mar=%h want 5", IO_data_out, MAR_data);
        end
    endtask

    initial begin
        clear_all();
        MDR_data = '0;
        IO_data_in = '0;
        test_reset();
        test_rf_load();
        test_alu_logic();
        test_muldiv();
        test_shift_unary();
        test_special_regs();
        test_priority();
        test_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
